// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a bounded grant length and a one-cycle gap between owners.
// Latency: one cycle from request to grant; every output comes straight from a register.
// Backpressure: requesters hold req until granted; a long grant is cut at TIMEOUT cycles.
module bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_id,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   gnt_id_q;
    logic [IW-1:0]   last_owner_q;
    logic            busy_q;
    logic            timeout_err_q;
    logic [CW-1:0]   cnt_q;

    // Arbitration result for the next edge
    logic            win_vld_d;
    logic [IW-1:0]   win_idx_d;
    logic [NREQ-1:0] win_onehot_d;

    // Conditions of the current owner while in GRANT
    logic            owner_req;
    logic            owner_done;
    logic            cnt_max;
    logic            grant_end_d;
    logic            timeout_err_d;

    // Round-robin search starting just above the last owner; descending loop so the
    // nearest candidate is the one assigned last and therefore wins.
    always_comb begin
        logic [IW-1:0] cand;
        int            sum;
        win_vld_d    = 1'b0;
        win_idx_d    = '0;
        cand         = '0;
        sum          = 0;
        for (int k = NREQ; k >= 1; k--) begin
            sum  = (int'(last_owner_q) + k) % NREQ;
            cand = IW'(sum);
            if (req[cand]) begin
                win_vld_d = 1'b1;
                win_idx_d = cand;
            end
        end
        win_onehot_d            = '0;
        win_onehot_d[win_idx_d] = 1'b1;
    end

    // Release decision for the current owner; done wins over the timeout so an
    // orderly finish on the last allowed cycle is never flagged as an error.
    always_comb begin
        owner_req     = req[gnt_id_q];
        owner_done    = done[gnt_id_q];
        cnt_max       = (cnt_q == CW'(TIMEOUT - 1));
        grant_end_d   = owner_done || !owner_req || cnt_max;
        timeout_err_d = cnt_max && owner_req && !owner_done;
    end

    // Arbiter FSM; all outputs are registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            gnt_q         <= '0;
            gnt_id_q      <= '0;
            last_owner_q  <= IW'(NREQ - 1);
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            timeout_err_q <= 1'b0;
            case (state_q)
                // RELEASE arbitrates exactly like IDLE, so it always lasts one cycle
                S_IDLE, S_RELEASE: begin
                    if (win_vld_d) begin
                        state_q      <= S_GRANT;
                        gnt_q        <= win_onehot_d;
                        gnt_id_q     <= win_idx_d;
                        last_owner_q <= win_idx_d;
                        busy_q       <= 1'b1;
                        cnt_q        <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                S_GRANT: begin
                    if (grant_end_d) begin
                        state_q       <= S_RELEASE;
                        gnt_q         <= '0;
                        busy_q        <= 1'b0;
                        timeout_err_q <= timeout_err_d;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters sharing the bus (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 16, giving the maximum grant length in cycles (2..256).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port req, input, NREQ bits: per-requester bus request, level, held until granted.
REQ-006 The block SHALL have port done, input, NREQ bits: per-requester end-of-transfer pulse.
REQ-007 The block SHALL have port gnt, output, NREQ bits: one-hot bus grant, or all-zero.
REQ-008 The block SHALL have port gnt_id, output, $clog2(NREQ) bits: binary index of the current or last owner.
REQ-009 The block SHALL have port busy, output, 1 bit: high while any grant is active.
REQ-010 The block SHALL have port timeout_err, output, 1 bit: single-cycle pulse on forced release.

Function
REQ-011 The block SHALL register all outputs; there SHALL be no combinational path from any input to any output.
REQ-012 The block SHALL implement three states: IDLE, GRANT and RELEASE.
REQ-013 In IDLE with req nonzero at a rising edge, the block SHALL go to GRANT at that edge, with gnt and gnt_id set to the winner (1-cycle latency).
REQ-014 Winner selection SHALL be round-robin: the first set req bit searching upward from last_owner+1, wrapping from NREQ-1 to 0.
REQ-015 last_owner SHALL update to the winner at every grant.
REQ-016 In IDLE with req all-zero, the block SHALL stay in IDLE with gnt=0.
REQ-017 In GRANT, gnt SHALL stay constant while req[owner]=1, done[owner]=0 and the grant counter is below TIMEOUT-1.
REQ-018 The grant counter SHALL be 0 in the first GRANT cycle, increment once per GRANT cycle, and be cleared on entry to GRANT.
REQ-019 GRANT SHALL exit to RELEASE on any of: done[owner]=1, req[owner]=0, or counter=TIMEOUT-1; gnt SHALL be 0 from that edge.
REQ-020 timeout_err SHALL pulse for exactly one cycle, coincident with the first RELEASE cycle, only when the exit cause is the counter.
REQ-021 If done[owner] and the timeout occur in the same cycle, done SHALL take priority and timeout_err SHALL stay 0.
REQ-022 done and req changes from non-owners during GRANT SHALL be ignored; done bits SHALL be ignored outside GRANT.
REQ-023 RELEASE SHALL last exactly one cycle with gnt=0, then go to GRANT (REQ-013/014 arbitration) if req is nonzero, else to IDLE.
REQ-024 Consecutive grants SHALL therefore be separated by exactly one cycle with gnt=0.
REQ-025 busy SHALL equal (state==GRANT); gnt_id SHALL hold its value while not in GRANT.
REQ-026 gnt SHALL never have more than one bit set.

Reset
REQ-027 When rst_n=0, asynchronously: state=IDLE, gnt=0, gnt_id=0, busy=0, timeout_err=0, counter=0, last_owner=NREQ-1 (requester 0 has first priority).
REQ-028 Reset asserted mid-GRANT SHALL drop gnt immediately, without waiting for a clock edge and without a timeout_err pulse.
REQ-029 After rst_n deasserts, the first arbitration SHALL occur at the first rising edge with rst_n=1.

Verification (NREQ=4, TIMEOUT=8)
REQ-030 Scenario: after reset, req=4'b1010 -> next cycle gnt=4'b0010, gnt_id=1, busy=1.
REQ-031 Scenario: owner 1 pulses done with req=4'b1010 held -> gnt=0 for one cycle, then gnt=4'b1000, gnt_id=3.
REQ-032 Scenario: req=4'b1111 held, owner pulses done 2 cycles after each grant -> grant order 0,1,2,3,0, one idle cycle between grants.
REQ-033 Scenario: owner 2 holds req with no done -> gnt=4'b0100 for exactly 8 cycles, then gnt=0 and timeout_err=1 for 1 cycle.
REQ-034 Scenario: done[owner] on the 8th grant cycle -> release occurs with timeout_err=0; owner drops req mid-grant -> release next edge with timeout_err=0.
REQ-035 Scenario: rst_n pulsed low mid-grant of owner 3 with req=4'b1001 -> gnt=0 immediately; after release, first grant goes to requester 0 (gnt=4'b0001).
